// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter sharing the write port of one enabled register among
// NUM_REQ requesters. GNT/E/D are registered and the shared register Q loads D
// one edge later, so request-to-Q latency is two clocks. A grantee that holds
// both REQ and LOCK keeps the grant, and its data is re-captured every edge.
module rr_reg_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          C,
  input  logic                          R,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ-1:0]            LOCK,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_D,
  output logic [NUM_REQ-1:0]            GNT,
  output logic                          E,
  output logic [DATA_WIDTH-1:0]         D,
  output logic [DATA_WIDTH-1:0]         Q
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]           ptr;
  logic [PW-1:0]           gidx;
  logic [PW-1:0]           win;
  logic [PW-1:0]           off;
  logic [PW-1:0]           sel;
  logic [PW-1:0]           ptr_nxt;
  logic [PW:0]             win_sum;
  logic [2*NUM_REQ-1:0]    req_rot2;
  logic [NUM_REQ-1:0]      req_rot;
  logic [NUM_REQ-1:0]      win_oh;
  logic [DATA_WIDTH-1:0]   d_sel;
  logic                    found;
  logic                    lock_hit;

  // Rotate requests so bit 0 is the pointer position, pick the lowest set
  // offset, then map it back to an absolute requester index.
  always_comb begin
    req_rot2 = {REQ, REQ} >> ptr;
    req_rot  = req_rot2[NUM_REQ-1:0];
    found    = |req_rot;
    off      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = PW'(i);
    end
    win_sum = {1'b0, ptr} + {1'b0, off};
    if (win_sum >= (PW+1)'(NUM_REQ)) win_sum = win_sum - (PW+1)'(NUM_REQ);
    win     = win_sum[PW-1:0];
    ptr_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
  end

  // Lock hold applies only to the current grantee; GNT is one-hot or zero.
  always_comb begin
    lock_hit = |(GNT & REQ & LOCK);
    sel      = lock_hit ? gidx : win;
    d_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == PW'(i)) d_sel = REQ_D[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant, write-enable, write-data and round-robin pointer registers.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      GNT  <= '0;
      gidx <= '0;
      ptr  <= '0;
      E    <= 1'b0;
      D    <= '0;
    end else if (lock_hit) begin
      E <= 1'b1;
      D <= d_sel;
    end else if (found) begin
      GNT  <= win_oh;
      gidx <= win;
      ptr  <= ptr_nxt;
      E    <= 1'b1;
      D    <= d_sel;
    end else begin
      GNT <= '0;
      E   <= 1'b0;
    end
  end

  // Shared enabled register, fed by the registered write port.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      Q <= '0;
    end else if (E) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Self-checking bench for rr_reg_write_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_rr_reg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*DW-1:0] req_d;
  logic [N-1:0]    gnt;
  logic            e;
  logic [DW-1:0]   d;
  logic [DW-1:0]   q;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: grantee index (-1 none), pointer, port, register.
  int            m_g   = -1;
  int            m_ptr = 0;
  logic          m_e   = 1'b0;
  logic [DW-1:0] m_d   = '0;
  logic [DW-1:0] m_q   = '0;

  rr_reg_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .C(clk), .R(rst_n), .REQ(req), .LOCK(lock), .REQ_D(req_d),
    .GNT(gnt), .E(e), .D(d), .Q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: Q takes the old port value, then the port is re-arbitrated.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_g = -1; m_ptr = 0; m_e = 1'b0; m_d = '0; m_q = '0;
    end else begin
      if (m_e) m_q = m_d;
      if (m_g >= 0 && req[m_g] && lock[m_g]) begin
        m_e = 1'b1;
        m_d = req_d[m_g*DW +: DW];
      end else begin
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        if (w >= 0) begin
          m_g   = w;
          m_ptr = (w + 1) % N;
          m_e   = 1'b1;
          m_d   = req_d[w*DW +: DW];
        end else begin
          m_g = -1;
          m_e = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs against the model midway between active edges.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_gnt", 32'(gnt), (m_g >= 0) ? 32'(1) << m_g : 32'd0);
      chk("model_e",   32'(e),   32'(m_e));
      chk("model_d",   32'(d),   32'(m_d));
      chk("model_q",   32'(q),   32'(m_q));
    end
  end

  task automatic set_byte(input int idx, input logic [DW-1:0] v);
    req_d[idx*DW +: DW] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    req_d = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_e",   32'(e),   32'd0);
    chk("rst_d",   32'(d),   32'd0);
    chk("rst_q",   32'(q),   32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_q", 32'(q), 32'd0);
    rst_n = 1'b1;

    // Round-robin with all requesters active.
    @(negedge clk); chk("rr_gnt0", 32'(gnt), 32'h1); chk("rr_q0", 32'(q), 32'h00);
    @(negedge clk); chk("rr_gnt1", 32'(gnt), 32'h2); chk("rr_q1", 32'(q), 32'h11);
    @(negedge clk); chk("rr_gnt2", 32'(gnt), 32'h4); chk("rr_q2", 32'(q), 32'h22);
    @(negedge clk); chk("rr_gnt3", 32'(gnt), 32'h8); chk("rr_q3", 32'(q), 32'h33);
    @(negedge clk); chk("rr_gnt4", 32'(gnt), 32'h1); chk("rr_q4", 32'(q), 32'h44);

    // Wrap/skip from pointer 1 with requesters 0 and 3.
    req = 4'b1001;
    @(negedge clk); chk("wrap_gnt3", 32'(gnt), 32'h8);
    @(negedge clk); chk("wrap_gnt0", 32'(gnt), 32'h1);
    @(negedge clk); chk("wrap_gnt3b", 32'(gnt), 32'h8);

    // Lock hold on requester 2 with live data.
    req = 4'b0100; lock = 4'b0100; set_byte(2, 8'hA0);
    @(negedge clk); chk("lock_gnt_a", 32'(gnt), 32'h4); chk("lock_d_a", 32'(d), 32'hA0);
    req = 4'b1111;
    @(negedge clk); chk("lock_gnt_b", 32'(gnt), 32'h4); chk("lock_q_a", 32'(q), 32'hA0);
    @(negedge clk); chk("lock_gnt_c", 32'(gnt), 32'h4);
    set_byte(2, 8'hA1);
    @(negedge clk); chk("lock_gnt_d", 32'(gnt), 32'h4); chk("lock_d_b", 32'(d), 32'hA1);
    @(negedge clk); chk("lock_gnt_e", 32'(gnt), 32'h4); chk("lock_q_b", 32'(q), 32'hA1);
    lock = 4'b0000;
    @(negedge clk); chk("unlock_gnt", 32'(gnt), 32'h8);

    // Idle after writing 5A: Q and D hold.
    req = 4'b0001; set_byte(0, 8'h5A);
    @(negedge clk); chk("idle_wr_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_e", 32'(e), 32'd0);
      chk("idle_q", 32'(q), 32'h5A);
      chk("idle_d", 32'(d), 32'h5A);
    end

    // Reset asserted just before an edge that would load FF.
    req = 4'b0010; set_byte(1, 8'hFF);
    @(negedge clk); chk("mid_e", 32'(e), 32'd1); chk("mid_d", 32'(d), 32'hFF);
    #4 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_e", 32'(e), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    @(negedge clk); chk("mid_noload_q", 32'(q), 32'd0);
    req = 4'b1111; rst_n = 1'b1;
    @(negedge clk); chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req = 4'b0000;
      lock = 4'($urandom) & 4'($urandom);
      req_d = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
